// File: rtl/data_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_pkg
// Description : Shared types and constants for the 14-bit CPU data-memory
//               responder: responder state encoding, default bus widths
//               shared with the CPU top, and a wait-counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_pkg;

  // Default bus widths of the 14-bit CPU data-memory port
  localparam int DATA_W_DEF = 14;
  localparam int ADDR_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Width of a down-counter that must hold WAIT_CYC; never narrower than 1 bit
  function automatic int cnt_width(input int wait_cyc);
    return (wait_cyc < 1) ? 1 : $clog2(wait_cyc + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sp_mem_array.sv
`default_nettype none
// ============================================================================
// Module      : sp_mem_array
// Description : Single-port DEPTH x DATA_W storage with synchronous write and
//               a registered read port. One operation per enabled cycle.
//               clr turns the enabled cycle into "no write, zero the read
//               register" (used for out-of-range accesses).
// Ports       : clk, rst   - clock, async active-high reset (read reg only)
//               en         - perform an operation this edge
//               we         - 1 = write, 0 = read
//               clr        - suppress the write and clear the read register
//               idx        - word index
//               wdata      - write data
//               rdata      - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module sp_mem_array #(
  parameter int DATA_W = 14,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Storage is deliberately left out of reset so contents survive it
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en && we && !clr) begin
      r_mem[idx] <= wdata;
    end
  end

  // A write leaves the read register untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (en) begin
      if (clr) begin
        r_rdata <= '0;
      end else if (!we) begin
        r_rdata <= r_mem[idx];
      end
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Target end of the CPU data-memory request interface. Accepts
//               one request at a time, waits WAIT_CYC cycles, performs the
//               access on an internal array and answers with a one-cycle ack.
//               Out-of-range addresses complete with err and rdata = 0.
// Ports       : clk    - clock, rising edge
//               reset  - asynchronous active-high reset
//               req    - request, held by initiator until ack is seen
//               we     - 1 = write, 0 = read (sampled on acceptance)
//               addr   - word address
//               wdata  - write data
//               rdata  - registered read data, valid with ack
//               ack    - one-cycle completion pulse
//               err    - address out of range, valid with ack
//               busy   - state is not IDLE
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int CNT_W = cnt_width(WAIT_CYC);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0]  c_wait  = CNT_W'(WAIT_CYC);
  // One extra bit so DEPTH == 2**ADDR_W is representable
  localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack;
  logic              r_err;

  logic              w_access;
  logic              w_oor;
  logic [IDX_W-1:0]  w_idx;

  // The single array operation happens on the WAIT->ACK edge
  assign w_access = (r_state == WAIT) && (r_cnt == '0);
  assign w_oor    = ({1'b0, r_addr} >= c_depth);
  assign w_idx    = r_addr[IDX_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= c_wait;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_ack   <= 1'b1;
            r_err   <= w_oor;
            r_state <= ACK;
          end
        end
        ACK: begin
          // A still-held req must not look like a fresh request
          r_state <= req ? RELEASE : IDLE;
        end
        RELEASE: begin
          if (!req) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  sp_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (clk),
    .rst   (reset),
    .en    (w_access),
    .we    (r_we),
    .clr   (w_oor),
    .idx   (w_idx),
    .wdata (r_wdata),
    .rdata (rdata)
  );

  assign ack  = r_ack;
  assign err  = r_err;
  assign busy = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for data_mem_responder. Instance 0 uses
//               WAIT_CYC=2, instance 1 uses WAIT_CYC=0. Stimulus pushes the
//               hand-computed response; a monitor pops it on every ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  typedef struct {
    logic        err;
    logic [13:0] rd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req   [2];
  logic        we    [2];
  logic [11:0] addr  [2];
  logic [13:0] wdata [2];
  logic [13:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        busy  [2];

  exp_t sb0[$];
  exp_t sb1[$];

  int checks = 0;
  int errors = 0;
  int edge_no = 0;
  int ack_cnt [2];
  int last_acc [2];
  logic prev_ack [2];

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 1;

  data_mem_responder #(.DATA_W(14), .ADDR_W(12), .DEPTH(1024), .WAIT_CYC(2)) u_dut0 (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .rdata(rdata[0]), .ack(ack[0]), .err(err[0]), .busy(busy[0])
  );

  data_mem_responder #(.DATA_W(14), .ADDR_W(12), .DEPTH(1024), .WAIT_CYC(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .rdata(rdata[1]), .ack(ack[1]), .err(err[1]), .busy(busy[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ack[d] === 1'b1) begin
        exp_t e;
        bit   have;
        ack_cnt[d]++;
        chk($sformatf("ack_width_d%0d", d), {31'd0, prev_ack[d]}, 32'd0);
        have = 1'b0;
        if (d == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
        if (d == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
        chk($sformatf("ack_expected_d%0d", d), {31'd0, have}, 32'd1);
        if (have) begin
          chk($sformatf("err_d%0d", d), {31'd0, err[d]}, {31'd0, e.err});
          chk($sformatf("rdata_d%0d", d), {18'd0, rdata[d]}, {18'd0, e.rd});
        end
      end
      prev_ack[d] = ack[d];
    end
  end

  // Issue one request starting now; edge 0 is the next rising edge.
  task automatic xfer(input int d, input bit w, input logic [11:0] a,
                      input logic [13:0] wd, input bit e_err, input logic [13:0] e_rd,
                      input int lat, input int per, input int hold);
    exp_t e;
    int   n;
    int   acks0;
    bit   got;
    e.err = e_err;
    e.rd  = e_rd;
    if (d == 0) sb0.push_back(e); else sb1.push_back(e);
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    got = 1'b0;
    n = -1;
    for (int i = 0; i <= 20; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        if (per > 0) chk("period", edge_no - last_acc[d], per);
        last_acc[d] = edge_no;
        acks0 = ack_cnt[d];
        chk("busy_after_accept", {31'd0, busy[d]}, 32'd1);
        // Later changes on the bus must not affect the latched request
        we[d] = ~w; addr[d] = ~a; wdata[d] = ~wd;
      end
      if (ack[d] === 1'b1) begin
        got = 1'b1;
        n = i;
        break;
      end
    end
    chk("ack_latency", n, got ? lat : 32'hFFFF_FFFF);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("busy_release", {31'd0, busy[d]}, 32'd1);
    end
    req[d] = 1'b0;
    @(posedge clk); #1;
    chk("busy_idle", {31'd0, busy[d]}, 32'd0);
    if (hold > 0) chk("single_ack_held", ack_cnt[d] - acks0, 1);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      ack_cnt[d] = 0; last_acc[d] = 0; prev_ack[d] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rdata", {18'd0, rdata[0]}, 32'd0);
    chk("rst_ack",   {31'd0, ack[0]},   32'd0);
    chk("rst_err",   {31'd0, err[0]},   32'd0);
    chk("rst_busy",  {31'd0, busy[0]},  32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_ack_idle", ack_cnt[0] + ack_cnt[1], 0);
    @(posedge clk); #1;

    // Instance 0, WAIT_CYC=2: latency 3, period 5
    xfer(0, 1'b1, 12'h010, 14'h02A5, 1'b0, 14'h0000, 3, 0, 0);
    xfer(0, 1'b0, 12'h010, 14'h0000, 1'b0, 14'h02A5, 3, 5, 0);
    xfer(0, 1'b1, 12'h000, 14'h0001, 1'b0, 14'h02A5, 3, 5, 0);
    xfer(0, 1'b1, 12'h400, 14'h1FFF, 1'b1, 14'h0000, 3, 5, 0);
    xfer(0, 1'b0, 12'h000, 14'h0000, 1'b0, 14'h0001, 3, 5, 0);
    xfer(0, 1'b1, 12'h005, 14'h0123, 1'b0, 14'h0001, 3, 5, 0);
    xfer(0, 1'b0, 12'h010, 14'h0000, 1'b0, 14'h02A5, 3, 5, 10);

    // Reset in the middle of a pending write
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 12'h005; wdata[0] = 14'h3FFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    req[0] = 1'b0;
    #1;
    chk("midrst_rdata", {18'd0, rdata[0]}, 32'd0);
    chk("midrst_ack",   {31'd0, ack[0]},   32'd0);
    chk("midrst_err",   {31'd0, err[0]},   32'd0);
    chk("midrst_busy",  {31'd0, busy[0]},  32'd0);
    begin
      int a0;
      a0 = ack_cnt[0];
      @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_ack", ack_cnt[0] - a0, 0);
    end
    @(posedge clk); #1;
    xfer(0, 1'b0, 12'h005, 14'h0000, 1'b0, 14'h0123, 3, 0, 0);

    // Instance 1, WAIT_CYC=0: latency 1, period 3
    xfer(1, 1'b1, 12'h020, 14'h0155, 1'b0, 14'h0000, 1, 0, 0);
    xfer(1, 1'b0, 12'h020, 14'h0000, 1'b0, 14'h0155, 1, 3, 0);
    xfer(1, 1'b1, 12'h3FF, 14'h3FFF, 1'b0, 14'h0155, 1, 3, 0);
    xfer(1, 1'b0, 12'h3FF, 14'h0000, 1'b0, 14'h3FFF, 1, 3, 0);
    xfer(1, 1'b0, 12'hFFF, 14'h0000, 1'b1, 14'h0000, 1, 3, 0);
    xfer(1, 1'b0, 12'h020, 14'h0000, 1'b0, 14'h0155, 1, 3, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb0.size() + sb1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
